gate_response_checker: RTL and testbench

Self-checking response monitor for a 2-input gate under test. Samples input vectors (`a`, `b`) and the observed DUT output (`out`) on each valid cycle. Compares `out` against the expected value of a selected boolean function, and accumulates vector count, failure count, input-combination coverage and the first failing vector. Sits opposite a stimulus driver: the driver applies vectors to the gate, and this block judges the responses and issues a pass/fail verdict, so benches need no hand-read waveforms.

---
 rtl/gate_response_checker_if.sv | 39 +++
 rtl/gate_response_checker.sv | 160 ++++++++++++++++
 tb/tb_gate_response_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_response_checker_if.sv
// ============================================================================
// Module   : gate_response_checker_if
// Brief    : Stimulus-side and result-side signals of the gate response checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       op;
    logic             valid;
    logic             a;
    logic             b;
    logic             out;
    logic             stop;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [3:0]       coverage;
    logic [2:0]       first_fail;
    logic             first_fail_vld;

    modport master (
        output start, op, valid, a, b, out, stop,
        input  busy, done, pass, vec_cnt, fail_cnt, coverage, first_fail, first_fail_vld
    );

    modport slave (
        input  start, op, valid, a, b, out, stop,
        output busy, done, pass, vec_cnt, fail_cnt, coverage, first_fail, first_fail_vld
    );
endinterface

`default_nettype wire

// File: rtl/gate_response_checker.sv
// ============================================================================
// Module   : gate_response_checker
// Brief    : Judges a 2-input gate's responses against a selected boolean
//            function and reports counts, coverage, first failure and verdict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_response_checker #(
    parameter int CNT_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    gate_response_checker_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_op_q;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [3:0]       r_coverage;
    logic [2:0]       r_first_fail;
    logic             r_first_fail_vld;

    logic             w_expected;
    logic             w_op_ok;
    logic             w_check;
    logic             w_finish;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_vec_cnt_nxt;
    logic [CNT_W-1:0] w_fail_cnt_nxt;
    logic [3:0]       w_coverage_nxt;
    logic [2:0]       w_first_fail_nxt;
    logic             w_first_fail_vld_nxt;
    logic             w_pass_nxt;

    // start wins over everything, so it masks both checking and stopping
    always_comb begin
        w_state_nxt = r_state;
        w_check     = 1'b0;
        w_finish    = 1'b0;
        if (bus.start) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            w_check  = bus.valid;
            w_finish = bus.stop;
            if (bus.stop) begin
                w_state_nxt = S_DONE;
            end
        end
    end

    always_comb begin
        w_expected = 1'b0;
        w_op_ok    = 1'b1;
        case (r_op_q)
            3'd0:    w_expected = bus.a & bus.b;
            3'd1:    w_expected = bus.a | bus.b;
            3'd2:    w_expected = bus.a ^ bus.b;
            3'd3:    w_expected = ~(bus.a & bus.b);
            3'd4:    w_expected = ~(bus.a | bus.b);
            3'd5:    w_expected = ~(bus.a ^ bus.b);
            default: w_op_ok    = 1'b0;
        endcase
    end

    // Post-update result values; the verdict is formed from these so a vector
    // arriving together with stop is included.
    always_comb begin
        w_mismatch           = w_check && (!w_op_ok || (bus.out != w_expected));
        w_vec_cnt_nxt        = r_vec_cnt;
        w_fail_cnt_nxt       = r_fail_cnt;
        w_coverage_nxt       = r_coverage;
        w_first_fail_nxt     = r_first_fail;
        w_first_fail_vld_nxt = r_first_fail_vld;

        if (w_check) begin
            if (r_vec_cnt != c_CNT_MAX) begin
                w_vec_cnt_nxt = r_vec_cnt + c_CNT_ONE;
            end
            w_coverage_nxt[{bus.a, bus.b}] = 1'b1;
        end

        if (w_mismatch) begin
            if (r_fail_cnt != c_CNT_MAX) begin
                w_fail_cnt_nxt = r_fail_cnt + c_CNT_ONE;
            end
            if (!r_first_fail_vld) begin
                w_first_fail_nxt     = {bus.a, bus.b, bus.out};
                w_first_fail_vld_nxt = 1'b1;
            end
        end

        w_pass_nxt = (w_fail_cnt_nxt == '0) && (w_coverage_nxt == 4'hF) && w_op_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_op_q           <= 3'd0;
            r_vec_cnt        <= '0;
            r_fail_cnt       <= '0;
            r_coverage       <= 4'h0;
            r_first_fail     <= 3'b000;
            r_first_fail_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);

            if (bus.start) begin
                r_pass           <= 1'b0;
                r_op_q           <= bus.op;
                r_vec_cnt        <= '0;
                r_fail_cnt       <= '0;
                r_coverage       <= 4'h0;
                r_first_fail     <= 3'b000;
                r_first_fail_vld <= 1'b0;
            end else begin
                r_vec_cnt        <= w_vec_cnt_nxt;
                r_fail_cnt       <= w_fail_cnt_nxt;
                r_coverage       <= w_coverage_nxt;
                r_first_fail     <= w_first_fail_nxt;
                r_first_fail_vld <= w_first_fail_vld_nxt;
                if (w_finish) begin
                    r_pass <= w_pass_nxt;
                end
            end
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.vec_cnt        = r_vec_cnt;
    assign bus.fail_cnt       = r_fail_cnt;
    assign bus.coverage       = r_coverage;
    assign bus.first_fail     = r_first_fail;
    assign bus.first_fail_vld = r_first_fail_vld;

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
// ============================================================================
// Module   : tb_gate_response_checker
// Brief    : Scoreboard bench; two checkers (8-bit and 2-bit counters) share
//            one stimulus stream so saturation is judged on every run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_response_checker;

    typedef struct {
        string    name;
        bit       pass;
        int       vec;
        int       fail;
        bit [3:0] cov;
        bit [2:0] ff;
        bit       ffv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r_start = 1'b0;
    logic [2:0] r_op = 3'd0;
    logic       r_valid = 1'b0;
    logic       r_a = 1'b0;
    logic       r_b = 1'b0;
    logic       r_out = 1'b0;
    logic       r_stop = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic r_done0_d = 1'b0;
    logic r_done1_d = 1'b0;

    // truth tables indexed by {a,b}
    logic [3:0] tt [6] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};

    gate_response_checker_if #(.CNT_W(8)) bus0 ();
    gate_response_checker_if #(.CNT_W(2)) bus1 ();

    assign bus0.start = r_start;  assign bus1.start = r_start;
    assign bus0.op    = r_op;     assign bus1.op    = r_op;
    assign bus0.valid = r_valid;  assign bus1.valid = r_valid;
    assign bus0.a     = r_a;      assign bus1.a     = r_a;
    assign bus0.b     = r_b;      assign bus1.b     = r_b;
    assign bus0.out   = r_out;    assign bus1.out   = r_out;
    assign bus0.stop  = r_stop;   assign bus1.stop  = r_stop;

    gate_response_checker #(.CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gate_response_checker #(.CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic score(input string dn, input exp_t e, input int pass, input int vec,
                         input int fail, input int cov, input int ff, input int ffv);
        chk({dn, ".", e.name, ".pass"},       pass, int'(e.pass));
        chk({dn, ".", e.name, ".vec_cnt"},    vec,  e.vec);
        chk({dn, ".", e.name, ".fail_cnt"},   fail, e.fail);
        chk({dn, ".", e.name, ".coverage"},   cov,  int'(e.cov));
        chk({dn, ".", e.name, ".first_fail"}, ff,   int'(e.ff));
        chk({dn, ".", e.name, ".ff_vld"},     ffv,  int'(e.ffv));
    endtask

    task automatic push_exp(input string nm, input bit pass, input int vec, input int fail,
                            input bit [3:0] cov, input bit [2:0] ff, input bit ffv);
        exp_t e;
        e.name = nm; e.pass = pass; e.vec = vec; e.fail = fail;
        e.cov = cov; e.ff = ff; e.ffv = ffv;
        q0.push_back(e);
        e.vec  = (vec  > 3) ? 3 : vec;
        e.fail = (fail > 3) ? 3 : fail;
        q1.push_back(e);
    endtask

    // Monitor: a rising done is the DUT presenting a verdict
    always @(negedge clk) begin
        if (bus0.done && !r_done0_d) begin
            if (q0.size() == 0) chk("d0.unexpected_done", 1, 0);
            else score("d0", q0.pop_front(), int'(bus0.pass), int'(bus0.vec_cnt),
                       int'(bus0.fail_cnt), int'(bus0.coverage), int'(bus0.first_fail),
                       int'(bus0.first_fail_vld));
        end
        if (bus1.done && !r_done1_d) begin
            if (q1.size() == 0) chk("d1.unexpected_done", 1, 0);
            else score("d1", q1.pop_front(), int'(bus1.pass), int'(bus1.vec_cnt),
                       int'(bus1.fail_cnt), int'(bus1.coverage), int'(bus1.first_fail),
                       int'(bus1.first_fail_vld));
        end
        r_done0_d <= bus0.done;
        r_done1_d <= bus1.done;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] op, input logic with_vec);
        r_start = 1'b1; r_op = op; r_stop = 1'b0;
        r_valid = with_vec; r_a = 1'b0; r_b = 1'b0; r_out = 1'b1;
        cyc();
        r_start = 1'b0; r_valid = 1'b0;
    endtask

    task automatic vec(input logic a, input logic b, input logic o, input logic last);
        r_valid = 1'b1; r_a = a; r_b = b; r_out = o; r_stop = last;
        cyc();
        r_valid = 1'b0; r_stop = 1'b0;
    endtask

    task automatic stop_only();
        r_stop = 1'b1;
        cyc();
        r_stop = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".busy"},     int'(bus0.busy), 0);
        chk({tag, ".done"},     int'(bus0.done), 0);
        chk({tag, ".pass"},     int'(bus0.pass), 0);
        chk({tag, ".vec_cnt"},  int'(bus0.vec_cnt), 0);
        chk({tag, ".fail_cnt"}, int'(bus0.fail_cnt), 0);
        chk({tag, ".coverage"}, int'(bus0.coverage), 0);
        chk({tag, ".ff"},       int'(bus0.first_fail), 0);
        chk({tag, ".ff_vld"},   int'(bus0.first_fail_vld), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(); cyc();
        chk_reset_state("reset");
        rst_n = 1'b1;
        cyc();

        // Every supported function, correct full truth table
        for (int op = 0; op < 6; op++) begin
            push_exp($sformatf("table_op%0d", op), 1'b1, 4, 0, 4'hF, 3'b000, 1'b0);
            do_start(3'(op), 1'b0);
            chk("busy_after_start", int'(bus0.busy), 1);
            for (int v = 0; v < 4; v++) begin
                vec(v[1], v[0], tt[op][v], v == 3);
            end
            chk("busy_after_stop", int'(bus0.busy), 0);
        end

        // Injected faults on AND
        push_exp("faults", 1'b0, 4, 2, 4'hF, 3'b011, 1'b1);
        do_start(3'd0, 1'b0);
        vec(0, 0, 0, 0); vec(0, 1, 1, 0); vec(1, 0, 0, 0); vec(1, 1, 0, 0);
        stop_only();

        // Incomplete coverage on XOR
        push_exp("partial_cov", 1'b0, 2, 0, 4'b0110, 3'b000, 1'b0);
        do_start(3'd2, 1'b0);
        vec(0, 1, 1, 0); vec(1, 0, 1, 0);
        stop_only();

        // start+valid ignored; valid+stop counted; back-to-back start
        push_exp("priority", 1'b1, 4, 0, 4'hF, 3'b000, 1'b0);
        do_start(3'd1, 1'b0);
        do_start(3'd0, 1'b1);
        chk("start_valid.vec_cnt", int'(bus0.vec_cnt), 0);
        vec(0, 0, 0, 0); vec(0, 1, 0, 0); vec(1, 0, 0, 0); vec(1, 1, 1, 1);

        // Five OR failures: 2-bit checker saturates at 3
        push_exp("saturate", 1'b0, 5, 5, 4'hF, 3'b001, 1'b1);
        do_start(3'd1, 1'b0);
        vec(0, 0, 1, 0); vec(0, 1, 0, 0); vec(1, 0, 0, 0); vec(1, 1, 0, 0); vec(0, 0, 1, 0);
        stop_only();
        vec(0, 0, 1, 0); vec(0, 1, 0, 0);
        chk("hold.d1.fail_cnt", int'(bus1.fail_cnt), 3);
        chk("hold.d0.fail_cnt", int'(bus0.fail_cnt), 5);
        chk("hold.done", int'(bus0.done), 1);

        // Reset mid-run
        do_start(3'd0, 1'b0);
        vec(0, 0, 1, 0); vec(1, 1, 1, 0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_reset_state("midrun_reset");
        vec(1, 1, 0, 0);
        chk("post_reset_valid.vec_cnt", int'(bus0.vec_cnt), 0);
        chk("post_reset_valid.ff_vld", int'(bus0.first_fail_vld), 0);

        // Reserved op: every vector fails
        push_exp("reserved_op", 1'b0, 4, 4, 4'hF, 3'b000, 1'b1);
        do_start(3'd6, 1'b0);
        vec(0, 0, 0, 0); vec(0, 1, 0, 0); vec(1, 0, 0, 0); vec(1, 1, 1, 1);

        cyc(); cyc();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
